// File: rtl/ifetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package ifetch_queue_pkg;

    localparam int          DEPTH_DEFAULT    = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pcplus4;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Sequential word address; wraps from 32'hFFFF_FFFC to 0.
    function automatic logic [31:0] nextPc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush and occupancy output; storage is not reset.
module sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] popData,
    output logic [CW-1:0]     occupancy
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic [CW-1:0]     count;
    logic              doPush;
    logic              doPop;

    // Flush wins over both push and pop in the same cycle.
    assign doPush = push && !flush;
    assign doPop  = pop && (count != '0) && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    assign popData   = mem[rdPtr];
    assign occupancy = count;

    a_noOverflow: assert property (@(posedge clk) disable iff (rst)
        doPush |-> (count < CW'(DEPTH)) || doPop);
    a_countBound: assert property (@(posedge clk) disable iff (rst)
        count <= CW'(DEPTH));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited request issue, in-order response
// capture, and redirect handling that discards responses to stale requests.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        deq,
    output logic        validF,
    output logic [31:0] insF,
    output logic [31:0] pcplus4F
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetchPc;
    logic [31:0]   respPc;
    logic [CW-1:0] occ;
    logic [CW-1:0] outst;
    logic [CW-1:0] drop;
    logic [CW:0]   credits;
    logic          grant;
    logic          enq;
    logic          pop;
    entry_t        tailEntry;
    entry_t        headEntry;

    // Every held entry and every in-flight request consumes one slot.
    assign credits   = {1'b0, occ} + {1'b0, outst};
    assign imem_req  = !rst && !redirect && (credits < (CW+1)'(DEPTH));
    assign imem_addr = fetchPc;
    assign grant     = imem_req && imem_gnt;

    assign enq       = imem_rvalid && (drop == '0) && !redirect;
    assign pop       = deq && validF && !redirect;
    assign tailEntry = '{insn: imem_rdata, pcplus4: nextPc(respPc)};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc <= RESET_PC;
            respPc  <= RESET_PC;
            outst   <= '0;
            drop    <= '0;
        end else if (redirect) begin
            // Every request still in flight is now stale, including ones
            // already marked for dropping; outst counts all of them.
            fetchPc <= redirect_pc;
            respPc  <= redirect_pc;
            outst   <= outst - CW'(imem_rvalid);
            drop    <= outst - CW'(imem_rvalid);
        end else begin
            if (grant) fetchPc <= nextPc(fetchPc);
            if (enq)   respPc  <= nextPc(respPc);
            outst <= outst + CW'(grant) - CW'(imem_rvalid);
            if (imem_rvalid && (drop != '0)) drop <= drop - 1'b1;
        end
    end

    sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_entries (
        .clk       (clk),
        .rst       (rst),
        .push      (enq),
        .pushData  (tailEntry),
        .pop       (pop),
        .flush     (redirect),
        .popData   (headEntry),
        .occupancy (occ)
    );

    assign validF   = (occ != '0);
    assign insF     = validF ? headEntry.insn    : NOP;
    assign pcplus4F = validF ? headEntry.pcplus4 : 32'h0;

    a_creditBound: assert property (@(posedge clk) disable iff (rst)
        credits <= (CW+1)'(DEPTH));
    a_noOrphanResp: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (outst != '0));
    a_dropWithinOutst: assert property (@(posedge clk) disable iff (rst)
        drop <= outst);
    a_enqNotFull: assert property (@(posedge clk) disable iff (rst)
        enq |-> (occ < CW'(DEPTH)) || pop);

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an in-order memory model answering one cycle after grant.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq;
    logic        validF;
    logic [31:0] insF;
    logic [31:0] pcplus4F;

    int          checks   = 0;
    int          failures = 0;
    logic        gntEn;
    logic        rvEn;
    logic [31:0] pend[$];
    logic [63:0] delivered[$];
    int          grants;
    logic        lastReq;
    logic [31:0] lastAddr;
    logic        lastValid;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq         (deq),
        .validF      (validF),
        .insF        (insF),
        .pcplus4F    (pcplus4F)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] insnFor(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Called at a falling edge with rst/deq/redirect already set.
    task automatic cycle();
        imem_gnt = gntEn;
        if (rvEn && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = insnFor(pend[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        lastReq   = imem_req;
        lastAddr  = imem_addr;
        lastValid = validF;
        if (deq && validF && !redirect && !rst) delivered.push_back({insF, pcplus4F});
        if (imem_rvalid) void'(pend.pop_front());
        if (imem_req && imem_gnt) begin
            grants++;
            pend.push_back(imem_addr);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic resetAll();
        rst = 1'b1; deq = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        gntEn = 1'b0; rvEn = 1'b0;
        pend.delete();
        cycle();
        cycle();
        delivered.delete();
        grants = 0;
    endtask

    task automatic test_reset();
        resetAll();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        checks++; if (validF !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", validF); end
        checks++; if (insF !== 32'h0) begin failures++; $display("FAIL reset_ins: got %h want 00000000", insF); end
        checks++; if (pcplus4F !== 32'h0) begin failures++; $display("FAIL reset_pc4: got %h want 00000000", pcplus4F); end
    endtask

    task automatic test_stream();
        resetAll();
        rst = 1'b0; deq = 1'b1; gntEn = 1'b1; rvEn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            checks++;
            if (lastReq !== 1'b1 || lastAddr !== 32'(4 * c)) begin
                failures++; $display("FAIL stream_addr c=%0d: got req=%b addr=%h want req=1 addr=%h", c, lastReq, lastAddr, 32'(4 * c));
            end
            checks++;
            if (lastValid !== (c >= 2)) begin
                failures++; $display("FAIL stream_valid c=%0d: got %b want %b", c, lastValid, (c >= 2));
            end
        end
        checks++;
        if (delivered.size() != 8) begin
            failures++; $display("FAIL stream_count: got %0d want 8", delivered.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (delivered[k] !== {insnFor(32'(4 * k)), 32'(4 * k + 4)}) begin
                    failures++; $display("FAIL stream_entry k=%0d: got %h want %h", k, delivered[k], {insnFor(32'(4 * k)), 32'(4 * k + 4)});
                end
            end
        end
    endtask

    task automatic test_credit();
        resetAll();
        rst = 1'b0; deq = 1'b0; gntEn = 1'b1; rvEn = 1'b1;
        repeat (8) cycle();
        checks++; if (grants != 4) begin failures++; $display("FAIL credit_grants: got %0d want 4", grants); end
        checks++; if (lastReq !== 1'b0) begin failures++; $display("FAIL credit_stall: got req=%b want 0", lastReq); end
        deq = 1'b1; cycle(); deq = 1'b0;
        repeat (4) cycle();
        checks++; if (grants != 5) begin failures++; $display("FAIL credit_pop1_grants: got %0d want 5", grants); end
        checks++; if (lastReq !== 1'b0) begin failures++; $display("FAIL credit_pop1_stall: got req=%b want 0", lastReq); end
        checks++;
        if (delivered.size() != 1 || delivered[0] !== {insnFor(32'h0), 32'h4}) begin
            failures++; $display("FAIL credit_head: got n=%0d want n=1 entry %h", delivered.size(), {insnFor(32'h0), 32'h4});
        end
        deq = 1'b1; cycle(); deq = 1'b0; cycle();
        checks++;
        if (lastReq !== 1'b1 || lastAddr !== 32'h14) begin
            failures++; $display("FAIL credit_pop2_req: got req=%b addr=%h want req=1 addr=00000014", lastReq, lastAddr);
        end
        repeat (3) cycle();
        checks++; if (grants != 6) begin failures++; $display("FAIL credit_pop2_grants: got %0d want 6", grants); end
    endtask

    task automatic test_redirect();
        logic anyValid;
        resetAll();
        rst = 1'b0; deq = 1'b1; gntEn = 1'b1; rvEn = 1'b0;
        repeat (3) cycle();
        checks++; if (grants != 3) begin failures++; $display("FAIL redir_outst: got %0d grants want 3", grants); end
        gntEn = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        checks++; if (lastReq !== 1'b0) begin failures++; $display("FAIL redir_req_gated: got %b want 0", lastReq); end
        redirect = 1'b0; gntEn = 1'b1; rvEn = 1'b1;
        anyValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (i == 0) begin
                checks++;
                if (lastReq !== 1'b1 || lastAddr !== 32'h100) begin
                    failures++; $display("FAIL redir_first_req: got req=%b addr=%h want req=1 addr=00000100", lastReq, lastAddr);
                end
            end
            anyValid = anyValid | lastValid;
        end
        checks++; if (anyValid !== 1'b0) begin failures++; $display("FAIL redir_stale_visible: got validF=%b want 0", anyValid); end
        repeat (4) cycle();
        checks++;
        if (delivered.size() < 2) begin
            failures++; $display("FAIL redir_count: got %0d want >=2", delivered.size());
        end else begin
            checks++;
            if (delivered[0] !== {insnFor(32'h100), 32'h104}) begin
                failures++; $display("FAIL redir_entry0: got %h want %h", delivered[0], {insnFor(32'h100), 32'h104});
            end
            checks++;
            if (delivered[1] !== {insnFor(32'h104), 32'h108}) begin
                failures++; $display("FAIL redir_entry1: got %h want %h", delivered[1], {insnFor(32'h104), 32'h108});
            end
        end
    endtask

    task automatic test_back_to_back();
        resetAll();
        rst = 1'b0; deq = 1'b1; gntEn = 1'b1; rvEn = 1'b0;
        repeat (3) cycle();
        rvEn = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0300;
        cycle();
        redirect_pc = 32'h0000_0200;
        cycle();
        redirect = 1'b0;
        cycle();
        checks++;
        if (lastReq !== 1'b1 || lastAddr !== 32'h200) begin
            failures++; $display("FAIL b2b_first_req: got req=%b addr=%h want req=1 addr=00000200", lastReq, lastAddr);
        end
        repeat (6) cycle();
        checks++;
        if (delivered.size() != 5) begin
            failures++; $display("FAIL b2b_count: got %0d want 5", delivered.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (delivered[k] !== {insnFor(32'h200 + 32'(4 * k)), 32'h204 + 32'(4 * k)}) begin
                    failures++; $display("FAIL b2b_entry k=%0d: got %h want %h", k, delivered[k], {insnFor(32'h200 + 32'(4 * k)), 32'h204 + 32'(4 * k)});
                end
            end
        end
    endtask

    task automatic test_wrap();
        resetAll();
        rst = 1'b0; deq = 1'b1; gntEn = 1'b1; rvEn = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        cycle();
        checks++; if (lastAddr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr_top: got %h want fffffffc", lastAddr); end
        cycle();
        checks++; if (lastAddr !== 32'h0) begin failures++; $display("FAIL wrap_addr_zero: got %h want 00000000", lastAddr); end
        repeat (3) cycle();
        checks++;
        if (delivered.size() < 2) begin
            failures++; $display("FAIL wrap_count: got %0d want >=2", delivered.size());
        end else begin
            checks++;
            if (delivered[0] !== {insnFor(32'hFFFF_FFFC), 32'h0}) begin
                failures++; $display("FAIL wrap_entry0: got %h want %h", delivered[0], {insnFor(32'hFFFF_FFFC), 32'h0});
            end
            checks++;
            if (delivered[1] !== {insnFor(32'h0), 32'h4}) begin
                failures++; $display("FAIL wrap_entry1: got %h want %h", delivered[1], {insnFor(32'h0), 32'h4});
            end
        end
    endtask

    task automatic test_midreset();
        resetAll();
        rst = 1'b0; deq = 1'b1; gntEn = 1'b1; rvEn = 1'b1;
        repeat (6) cycle();
        checks++; if (lastValid !== 1'b1) begin failures++; $display("FAIL midrst_running: got validF=%b want 1", lastValid); end
        rst = 1'b1;
        pend.delete();
        cycle();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL midrst_req: got %b want 0", imem_req); end
        checks++; if (validF !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", validF); end
        checks++; if (insF !== 32'h0) begin failures++; $display("FAIL midrst_ins: got %h want 00000000", insF); end
        checks++; if (pcplus4F !== 32'h0) begin failures++; $display("FAIL midrst_pc4: got %h want 00000000", pcplus4F); end
        delivered.delete();
        rst = 1'b0;
        cycle();
        checks++;
        if (lastReq !== 1'b1 || lastAddr !== 32'h0) begin
            failures++; $display("FAIL midrst_first_req: got req=%b addr=%h want req=1 addr=00000000", lastReq, lastAddr);
        end
        repeat (3) cycle();
        checks++;
        if (delivered.size() < 1 || delivered[0] !== {insnFor(32'h0), 32'h4}) begin
            failures++; $display("FAIL midrst_entry0: got n=%0d want first entry %h", delivered.size(), {insnFor(32'h0), 32'h4});
        end
    endtask

    initial begin
        rst = 1'b1; deq = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        gntEn = 1'b0; rvEn = 1'b0; grants = 0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_credit();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
